control_unit: RTL and testbench



---
 rtl/control_pkg.sv | 105 ++++++++++
 rtl/control_unit_if.sv | 37 +++
 rtl/control_unit_instr_decode.sv | 29 ++
 rtl/control_unit.sv | 151 +++++++++++++++
 tb/tb_control_unit.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/control_pkg.sv
// Shared encodings for the hardwired control sequencer: opcodes, ALU
// control codes, FSM state names, instruction classes and the strobe bundle.
package control_pkg;

  // Opcode field IR[31:27]
  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_BR   = 5'b10010;
  localparam logic [4:0] OP_JR   = 5'b10011;
  localparam logic [4:0] OP_JAL  = 5'b10100;
  localparam logic [4:0] OP_IN   = 5'b10101;
  localparam logic [4:0] OP_OUT  = 5'b10110;
  localparam logic [4:0] OP_MFHI = 5'b10111;
  localparam logic [4:0] OP_MFLO = 5'b11000;
  localparam logic [4:0] OP_NOP  = 5'b11001;
  localparam logic [4:0] OP_HALT = 5'b11010;

  // ALU ctrl codes
  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;

  // Execute steps are qualified by instruction class so the output decode
  // depends on the state register alone.
  typedef enum logic [4:0] {
    RESET, T0, T1, T2,
    ALU_T3, ALU_T4, ALU_T5,
    IMM_T3, IMM_T4, IMM_T5,
    LD_T3, LD_T4, LD_T5, LD_T6, LD_T7,
    ST_T3, ST_T4, ST_T5, ST_T6, ST_T7,
    JAL_T3, JAL_T4,
    JR_T3,
    BR_T3, BR_T4, BR_T5, BR_T6,
    IN_T3, OUT_T3, MFHI_T3, MFLO_T3,
    HALT
  } state_t;

  // One-hot instruction class
  typedef struct packed {
    logic alu;
    logic imm;
    logic ld;
    logic st;
    logic br;
    logic jal;
    logic jr;
    logic inp;
    logic outp;
    logic mfhi;
    logic mflo;
    logic halt;
    logic nop;
  } instr_class_t;

  // Every datapath control driven by the sequencer (Run excluded)
  typedef struct packed {
    logic       PCout;
    logic       Zlowout;
    logic       Zhighout;
    logic       MDRout;
    logic       HIout;
    logic       LOout;
    logic       InPortout;
    logic       Cout;
    logic       BAout;
    logic       Rout;
    logic       PCin;
    logic       MARin;
    logic       MDRin;
    logic       IRin;
    logic       Yin;
    logic       Zlowin;
    logic       Zhighin;
    logic       HIin;
    logic       LOin;
    logic       Rin;
    logic       Gra;
    logic       Grb;
    logic       Grc;
    logic       IncPC;
    logic       Read;
    logic       wren;
    logic       conInput;
    logic       outPortEnable;
    logic [3:0] ctrl;
  } strobes_t;

  // ALU operation for the register-register class
  function automatic logic [3:0] alu_ctrl_of(input logic [4:0] op);
    case (op)
      OP_SUB:  return ALU_SUB;
      OP_AND:  return ALU_AND;
      OP_OR:   return ALU_OR;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/control_unit_if.sv
// Control bundle between the sequencer and the datapath. There is no
// handshake: every strobe is a level that is valid for the whole clock cycle
// in which the sequencer holds the corresponding state.
interface control_unit_if;
  import control_pkg::*;

  logic [31:0] IR;
  logic        CON;
  logic        Stop;
  logic        Run;
  logic        PCout, Zlowout, Zhighout, MDRout, HIout, LOout, InPortout, Cout, BAout, Rout;
  logic        PCin, MARin, MDRin, IRin, Yin, Zlowin, Zhighin, HIin, LOin, Rin;
  logic        Gra, Grb, Grc;
  logic        IncPC, Read, wren, conInput, outPortEnable;
  logic [3:0]  ctrl;
  state_t      state;   // debug view of the sequencer state

  modport master (
    input  IR, CON, Stop,
    output Run,
    output PCout, Zlowout, Zhighout, MDRout, HIout, LOout, InPortout, Cout, BAout, Rout,
    output PCin, MARin, MDRin, IRin, Yin, Zlowin, Zhighin, HIin, LOin, Rin,
    output Gra, Grb, Grc,
    output IncPC, Read, wren, conInput, outPortEnable,
    output ctrl, state
  );

  modport slave (
    output IR, CON, Stop,
    input  Run,
    input  PCout, Zlowout, Zhighout, MDRout, HIout, LOout, InPortout, Cout, BAout, Rout,
    input  PCin, MARin, MDRin, IRin, Yin, Zlowin, Zhighin, HIin, LOin, Rin,
    input  Gra, Grb, Grc,
    input  IncPC, Read, wren, conInput, outPortEnable,
    input  ctrl, state
  );
endinterface

// File: rtl/control_unit_instr_decode.sv
// Opcode to one-hot instruction class; undefined opcodes behave as nop.
module instr_decode
  import control_pkg::*;
(
  input  logic [4:0]   opcode_i,
  output instr_class_t cls_o
);

  // Pure combinational class lookup
  always_comb begin
    cls_o = '0;
    case (opcode_i)
      OP_ADD, OP_SUB, OP_AND, OP_OR: cls_o.alu  = 1'b1;
      OP_ADDI, OP_LDI:               cls_o.imm  = 1'b1;
      OP_LD:                         cls_o.ld   = 1'b1;
      OP_ST:                         cls_o.st   = 1'b1;
      OP_BR:                         cls_o.br   = 1'b1;
      OP_JAL:                        cls_o.jal  = 1'b1;
      OP_JR:                         cls_o.jr   = 1'b1;
      OP_IN:                         cls_o.inp  = 1'b1;
      OP_OUT:                        cls_o.outp = 1'b1;
      OP_MFHI:                       cls_o.mfhi = 1'b1;
      OP_MFLO:                       cls_o.mflo = 1'b1;
      OP_HALT:                       cls_o.halt = 1'b1;
      default:                       cls_o.nop  = 1'b1;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Hardwired one-state-per-clock sequencer: shared fetch T0..T2, then a
// class-specific execute sequence, then back to T0 (or HALT on Stop).
module control_unit
  import control_pkg::*;
(
  input  logic           Clock,
  input  logic           Clear,
  control_unit_if.master cu
);

  state_t       state_q, state_d;
  logic [3:0]   alu_op_q, alu_op_d;
  instr_class_t cls;
  strobes_t     s;
  logic         unused_ir;

  assign unused_ir = ^cu.IR[26:0];

  instr_decode u_decode (
    .opcode_i (cu.IR[31:27]),
    .cls_o    (cls)
  );

  // Next state; ALU op is captured when the opcode is decoded in T2
  always_comb begin
    state_d  = state_q;
    alu_op_d = alu_op_q;
    case (state_q)
      RESET: state_d = T0;
      T0:    state_d = T1;
      T1:    state_d = T2;
      T2: begin
        alu_op_d = alu_ctrl_of(cu.IR[31:27]);
        if      (cls.alu)  state_d = ALU_T3;
        else if (cls.imm)  state_d = IMM_T3;
        else if (cls.ld)   state_d = LD_T3;
        else if (cls.st)   state_d = ST_T3;
        else if (cls.br)   state_d = BR_T3;
        else if (cls.jal)  state_d = JAL_T3;
        else if (cls.jr)   state_d = JR_T3;
        else if (cls.inp)  state_d = IN_T3;
        else if (cls.outp) state_d = OUT_T3;
        else if (cls.mfhi) state_d = MFHI_T3;
        else if (cls.mflo) state_d = MFLO_T3;
        else if (cls.halt) state_d = HALT;
        else               state_d = T0;
      end
      ALU_T3: state_d = ALU_T4;
      ALU_T4: state_d = ALU_T5;
      IMM_T3: state_d = IMM_T4;
      IMM_T4: state_d = IMM_T5;
      LD_T3:  state_d = LD_T4;
      LD_T4:  state_d = LD_T5;
      LD_T5:  state_d = LD_T6;
      LD_T6:  state_d = LD_T7;
      ST_T3:  state_d = ST_T4;
      ST_T4:  state_d = ST_T5;
      ST_T5:  state_d = ST_T6;
      ST_T6:  state_d = ST_T7;
      JAL_T3: state_d = JAL_T4;
      BR_T3:  state_d = BR_T4;
      BR_T4:  state_d = BR_T5;
      BR_T5:  state_d = BR_T6;
      ALU_T5, IMM_T5, LD_T7, ST_T7, JAL_T4, JR_T3, BR_T6,
      IN_T3, OUT_T3, MFHI_T3, MFLO_T3:
        state_d = cu.Stop ? HALT : T0;
      HALT:    state_d = HALT;
      default: state_d = RESET;
    endcase
  end

  // State register, cleared asynchronously by Clear
  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) begin
      state_q  <= RESET;
      alu_op_q <= ALU_ADD;
    end else begin
      state_q  <= state_d;
      alu_op_q <= alu_op_d;
    end
  end

  // Moore output decode; CON gates PCin only in the br T6 step
  always_comb begin
    s = '0;
    case (state_q)
      T0:     begin s.PCout = 1'b1; s.MARin = 1'b1; s.IncPC = 1'b1; s.Zlowin = 1'b1; end
      T1:     begin s.Zlowout = 1'b1; s.PCin = 1'b1; s.Read = 1'b1; s.MDRin = 1'b1; end
      T2:     begin s.MDRout = 1'b1; s.IRin = 1'b1; end
      ALU_T3: begin s.Grb = 1'b1; s.Rout = 1'b1; s.Yin = 1'b1; end
      ALU_T4: begin s.Grc = 1'b1; s.Rout = 1'b1; s.ctrl = alu_op_q; s.Zlowin = 1'b1; end
      IMM_T3, LD_T3, ST_T3:
              begin s.Grb = 1'b1; s.BAout = 1'b1; s.Yin = 1'b1; end
      IMM_T4, LD_T4, ST_T4:
              begin s.Cout = 1'b1; s.ctrl = ALU_ADD; s.Zlowin = 1'b1; end
      ALU_T5, IMM_T5:
              begin s.Zlowout = 1'b1; s.Gra = 1'b1; s.Rin = 1'b1; end
      LD_T5, ST_T5:
              begin s.Zlowout = 1'b1; s.MARin = 1'b1; end
      LD_T6:  begin s.Read = 1'b1; s.MDRin = 1'b1; end
      LD_T7:  begin s.MDRout = 1'b1; s.Gra = 1'b1; s.Rin = 1'b1; end
      ST_T6:  begin s.Gra = 1'b1; s.Rout = 1'b1; s.MDRin = 1'b1; end
      ST_T7:  begin s.wren = 1'b1; end
      JAL_T3: begin s.PCout = 1'b1; s.Grb = 1'b1; s.Rin = 1'b1; end
      JAL_T4, JR_T3:
              begin s.Gra = 1'b1; s.Rout = 1'b1; s.PCin = 1'b1; end
      BR_T3:  begin s.Gra = 1'b1; s.Rout = 1'b1; s.conInput = 1'b1; end
      BR_T4:  begin s.PCout = 1'b1; s.Yin = 1'b1; end
      BR_T5:  begin s.Cout = 1'b1; s.ctrl = ALU_ADD; s.Zlowin = 1'b1; end
      BR_T6:  begin s.Zlowout = 1'b1; s.PCin = cu.CON; end
      IN_T3:  begin s.InPortout = 1'b1; s.Gra = 1'b1; s.Rin = 1'b1; end
      OUT_T3: begin s.Gra = 1'b1; s.Rout = 1'b1; s.outPortEnable = 1'b1; end
      MFHI_T3: begin s.HIout = 1'b1; s.Gra = 1'b1; s.Rin = 1'b1; end
      MFLO_T3: begin s.LOout = 1'b1; s.Gra = 1'b1; s.Rin = 1'b1; end
      default: s = '0;
    endcase
  end

  assign cu.Run           = (state_q != RESET) && (state_q != HALT);
  assign cu.state         = state_q;
  assign cu.PCout         = s.PCout;
  assign cu.Zlowout       = s.Zlowout;
  assign cu.Zhighout      = s.Zhighout;
  assign cu.MDRout        = s.MDRout;
  assign cu.HIout         = s.HIout;
  assign cu.LOout         = s.LOout;
  assign cu.InPortout     = s.InPortout;
  assign cu.Cout          = s.Cout;
  assign cu.BAout         = s.BAout;
  assign cu.Rout          = s.Rout;
  assign cu.PCin          = s.PCin;
  assign cu.MARin         = s.MARin;
  assign cu.MDRin         = s.MDRin;
  assign cu.IRin          = s.IRin;
  assign cu.Yin           = s.Yin;
  assign cu.Zlowin        = s.Zlowin;
  assign cu.Zhighin       = s.Zhighin;
  assign cu.HIin          = s.HIin;
  assign cu.LOin          = s.LOin;
  assign cu.Rin           = s.Rin;
  assign cu.Gra           = s.Gra;
  assign cu.Grb           = s.Grb;
  assign cu.Grc           = s.Grc;
  assign cu.IncPC         = s.IncPC;
  assign cu.Read          = s.Read;
  assign cu.wren          = s.wren;
  assign cu.conInput      = s.conInput;
  assign cu.outPortEnable = s.outPortEnable;
  assign cu.ctrl          = s.ctrl;

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: the driver pushes the hand-written
// per-cycle control vector of each instruction into a queue, and a monitor
// pops and compares one vector on every falling clock edge.
module tb_control_unit;
  import control_pkg::*;

  localparam int W = 33;  // {Run, 28 strobes, ctrl[3:0]}
  localparam logic [W-1:0] ONE = 33'd1;

  localparam logic [W-1:0] M_RUN     = ONE << 32;
  localparam logic [W-1:0] M_PCOUT   = ONE << 31;
  localparam logic [W-1:0] M_ZLOWOUT = ONE << 30;
  localparam logic [W-1:0] M_MDROUT  = ONE << 28;
  localparam logic [W-1:0] M_HIOUT   = ONE << 27;
  localparam logic [W-1:0] M_LOOUT   = ONE << 26;
  localparam logic [W-1:0] M_INPOUT  = ONE << 25;
  localparam logic [W-1:0] M_COUT    = ONE << 24;
  localparam logic [W-1:0] M_BAOUT   = ONE << 23;
  localparam logic [W-1:0] M_ROUT    = ONE << 22;
  localparam logic [W-1:0] M_PCIN    = ONE << 21;
  localparam logic [W-1:0] M_MARIN   = ONE << 20;
  localparam logic [W-1:0] M_MDRIN   = ONE << 19;
  localparam logic [W-1:0] M_IRIN    = ONE << 18;
  localparam logic [W-1:0] M_YIN     = ONE << 17;
  localparam logic [W-1:0] M_ZLOWIN  = ONE << 16;
  localparam logic [W-1:0] M_RIN     = ONE << 12;
  localparam logic [W-1:0] M_GRA     = ONE << 11;
  localparam logic [W-1:0] M_GRB     = ONE << 10;
  localparam logic [W-1:0] M_GRC     = ONE << 9;
  localparam logic [W-1:0] M_INCPC   = ONE << 8;
  localparam logic [W-1:0] M_READ    = ONE << 7;
  localparam logic [W-1:0] M_WREN    = ONE << 6;
  localparam logic [W-1:0] M_CONIN   = ONE << 5;
  localparam logic [W-1:0] M_OUTPE   = ONE << 4;
  localparam logic [W-1:0] C_SUB     = 33'd1;
  localparam logic [W-1:0] C_AND     = 33'd2;
  localparam logic [W-1:0] C_OR      = 33'd3;

  localparam logic [W-1:0] V_T0 = M_RUN | M_PCOUT | M_MARIN | M_INCPC | M_ZLOWIN;
  localparam logic [W-1:0] V_T1 = M_RUN | M_ZLOWOUT | M_PCIN | M_READ | M_MDRIN;
  localparam logic [W-1:0] V_T2 = M_RUN | M_MDROUT | M_IRIN;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic clear_n = 1'b0;
  always #5 clk = ~clk;

  control_unit_if bus ();

  control_unit dut (
    .Clock (clk),
    .Clear (clear_n),
    .cu    (bus)
  );

  logic [W-1:0] act;
  assign act = {bus.Run, bus.PCout, bus.Zlowout, bus.Zhighout, bus.MDRout, bus.HIout,
                bus.LOout, bus.InPortout, bus.Cout, bus.BAout, bus.Rout, bus.PCin,
                bus.MARin, bus.MDRin, bus.IRin, bus.Yin, bus.Zlowin, bus.Zhighin,
                bus.HIin, bus.LOin, bus.Rin, bus.Gra, bus.Grb, bus.Grc, bus.IncPC,
                bus.Read, bus.wren, bus.conInput, bus.outPortEnable, bus.ctrl};

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           n_checks = 0;
  int           n_fail   = 0;

  task automatic check(input string n, input logic [W-1:0] a, input logic [W-1:0] e);
    n_checks++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", n, a, e);
    end
  endtask

  // Monitor: one expected vector per cycle, sampled mid-cycle
  initial begin
    logic [W-1:0] v;
    string        n;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        v = exp_q.pop_front();
        n = name_q.pop_front();
        check(n, act, v);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push(input logic [W-1:0] v, input string n);
    exp_q.push_back(v);
    name_q.push_back(n);
  endtask

  task automatic start_instr(input logic [31:0] ir, input logic con, input logic stop,
                             input string n);
    bus.IR   = ir;
    bus.CON  = con;
    bus.Stop = stop;
    push(V_T0, {n, ".T0"});
    push(V_T1, {n, ".T1"});
    push(V_T2, {n, ".T2"});
  endtask

  // Returns 1 ns after the rising edge that follows the last checked cycle
  task automatic wait_drain(input string n);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 200) begin
      @(posedge clk);
      k++;
    end
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s.timeout: %0d vectors left, required 0", n, exp_q.size());
      exp_q.delete();
      name_q.delete();
    end
    #1;
  endtask

  task automatic release_clear();
    @(negedge clk);
    clear_n = 1'b1;
    #1;
  endtask

  task automatic run_alu(input logic [31:0] ir, input logic [W-1:0] c, input string n);
    start_instr(ir, 1'b0, 1'b0, n);
    push(M_RUN | M_GRB | M_ROUT | M_YIN, {n, ".T3"});
    push(M_RUN | M_GRC | M_ROUT | M_ZLOWIN | c, {n, ".T4"});
    push(M_RUN | M_ZLOWOUT | M_GRA | M_RIN, {n, ".T5"});
    wait_drain(n);
  endtask

  task automatic push_imm_t3_t4(input string n);
    push(M_RUN | M_GRB | M_BAOUT | M_YIN, {n, ".T3"});
    push(M_RUN | M_COUT | M_ZLOWIN, {n, ".T4"});
  endtask

  task automatic run_one_step(input logic [31:0] ir, input logic [W-1:0] v, input string n);
    start_instr(ir, 1'b0, 1'b0, n);
    push(v, {n, ".T3"});
    wait_drain(n);
  endtask

  task automatic run_br(input logic con, input string n);
    start_instr(32'h9000_0000, con, 1'b0, n);
    push(M_RUN | M_GRA | M_ROUT | M_CONIN, {n, ".T3"});
    push(M_RUN | M_PCOUT | M_YIN, {n, ".T4"});
    push(M_RUN | M_COUT | M_ZLOWIN, {n, ".T5"});
    push(M_RUN | M_ZLOWOUT | (con ? M_PCIN : '0), {n, ".T6"});
    wait_drain(n);
  endtask

  task automatic hold_halt(input string n);
    for (int i = 0; i < 20; i++) push('0, {n, ".hold"});
    wait_drain(n);
    check({n, ".state"}, W'(bus.state), W'(HALT));
    clear_n = 1'b0;
    #1;
    check({n, ".clear"}, act, '0);
    release_clear();
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    bus.IR = 32'h0; bus.CON = 1'b0; bus.Stop = 1'b0;
    repeat (2) @(negedge clk);
    check("reset.outputs", act, '0);
    check("reset.state", W'(bus.state), W'(RESET));
    release_clear();
    check("release.outputs", act, '0);

    // Abort an add in T4
    start_instr(32'h1891_8000, 1'b0, 1'b0, "abort");
    push(M_RUN | M_GRB | M_ROUT | M_YIN, "abort.T3");
    wait_drain("abort");
    #1;
    check("abort.T4", act, M_RUN | M_GRC | M_ROUT | M_ZLOWIN);
    clear_n = 1'b0;
    #1;
    check("abort.clear", act, '0);
    check("abort.state", W'(bus.state), W'(RESET));
    release_clear();

    run_alu(32'h1891_8000, '0, "add");
    run_alu(32'h2000_0000, C_SUB, "sub");
    run_alu(32'h2800_0000, C_AND, "and");
    run_alu(32'h3000_0000, C_OR, "or");

    start_instr(32'h0080_0000, 1'b0, 1'b0, "ld");
    push_imm_t3_t4("ld");
    push(M_RUN | M_ZLOWOUT | M_MARIN, "ld.T5");
    push(M_RUN | M_READ | M_MDRIN, "ld.T6");
    push(M_RUN | M_MDROUT | M_GRA | M_RIN, "ld.T7");
    wait_drain("ld");

    start_instr(32'h1000_0000, 1'b0, 1'b0, "st");
    push_imm_t3_t4("st");
    push(M_RUN | M_ZLOWOUT | M_MARIN, "st.T5");
    push(M_RUN | M_GRA | M_ROUT | M_MDRIN, "st.T6");
    push(M_RUN | M_WREN, "st.T7");
    wait_drain("st");

    start_instr(32'h6000_0000, 1'b0, 1'b0, "addi");
    push_imm_t3_t4("addi");
    push(M_RUN | M_ZLOWOUT | M_GRA | M_RIN, "addi.T5");
    wait_drain("addi");

    start_instr(32'h0800_0000, 1'b0, 1'b0, "ldi");
    push_imm_t3_t4("ldi");
    push(M_RUN | M_ZLOWOUT | M_GRA | M_RIN, "ldi.T5");
    wait_drain("ldi");

    start_instr(32'hA080_0000, 1'b0, 1'b0, "jal");
    push(M_RUN | M_PCOUT | M_GRB | M_RIN, "jal.T3");
    push(M_RUN | M_GRA | M_ROUT | M_PCIN, "jal.T4");
    wait_drain("jal");

    run_one_step(32'h9800_0000, M_RUN | M_GRA | M_ROUT | M_PCIN, "jr");
    run_br(1'b1, "br_taken");
    run_br(1'b0, "br_not_taken");
    run_one_step(32'hA800_0000, M_RUN | M_INPOUT | M_GRA | M_RIN, "in");
    run_one_step(32'hB000_0000, M_RUN | M_GRA | M_ROUT | M_OUTPE, "out");
    run_one_step(32'hB800_0000, M_RUN | M_HIOUT | M_GRA | M_RIN, "mfhi");
    run_one_step(32'hC000_0000, M_RUN | M_LOOUT | M_GRA | M_RIN, "mflo");

    start_instr(32'hC800_0000, 1'b0, 1'b0, "nop");
    wait_drain("nop");
    start_instr(32'hF800_0000, 1'b0, 1'b0, "undef");
    wait_drain("undef");

    // halt opcode
    start_instr(32'hD000_0000, 1'b0, 1'b0, "halt");
    hold_halt("halt");

    // Stop held through a whole add: only its T5 honours it
    start_instr(32'h1891_8000, 1'b0, 1'b1, "stop");
    push(M_RUN | M_GRB | M_ROUT | M_YIN, "stop.T3");
    push(M_RUN | M_GRC | M_ROUT | M_ZLOWIN, "stop.T4");
    push(M_RUN | M_ZLOWOUT | M_GRA | M_RIN, "stop.T5");
    hold_halt("stop");

    // Clean restart after HALT
    run_alu(32'h2000_0000, C_SUB, "restart");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
